// File: rtl/sat_counter_arbiter.sv
// Two-requester round-robin front end for a saturating signed accumulator.
// Commands run IDLE -> EXEC -> RESP; the response is held until consumed.
module sat_counter_arbiter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_valid,
    input  logic [1:0]   req0_op,
    input  logic [W-1:0] req0_data,
    output logic         req0_ready,
    input  logic         req1_valid,
    input  logic [1:0]   req1_op,
    input  logic [W-1:0] req1_data,
    output logic         req1_ready,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [W-1:0] rsp_data,
    output logic         rsp_sat,
    output logic [W-1:0] q
);

    typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_LOAD = 2'b10;
    localparam logic [1:0] OP_READ = 2'b11;

    localparam logic [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    state_t       state_q;
    logic         last_q;
    logic         id_q;
    logic [1:0]   op_q;
    logic [W-1:0] data_q;
    logic [W-1:0] cnt_q;
    logic [W-1:0] rsp_data_q;
    logic         rsp_sat_q;
    logic         rsp_id_q;

    logic         idle;
    logic         grant;
    logic         gid;
    logic [W:0]   ext_q;
    logic [W:0]   ext_d;
    logic [W:0]   sum;
    logic         ovf;
    logic [W-1:0] res_d;
    logic         sat_d;

    // Ties go to the requester that was not served last.
    always_comb begin
        idle       = (state_q == IDLE);
        req0_ready = idle & req0_valid & (~req1_valid | last_q);
        req1_ready = idle & req1_valid & (~req0_valid | ~last_q);
        grant      = req0_ready | req1_ready;
        gid        = req1_ready;
    end

    // One extra bit of headroom makes overflow a simple sign-bit mismatch.
    always_comb begin
        ext_q = {cnt_q[W-1], cnt_q};
        ext_d = {data_q[W-1], data_q};
        sum   = ext_q;
        unique case (op_q)
            OP_ADD:  sum = ext_q + ext_d;
            OP_SUB:  sum = ext_q - ext_d;
            OP_LOAD: sum = ext_d;
            OP_READ: sum = ext_q;
            default: sum = ext_q;
        endcase
        ovf   = sum[W] ^ sum[W-1];
        sat_d = ovf;
        res_d = ovf ? (sum[W] ? MINV : MAXV) : sum[W-1:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            last_q     <= 1'b1;
            id_q       <= 1'b0;
            op_q       <= OP_ADD;
            data_q     <= '0;
            cnt_q      <= '0;
            rsp_data_q <= '0;
            rsp_sat_q  <= 1'b0;
            rsp_id_q   <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        op_q    <= gid ? req1_op : req0_op;
                        data_q  <= gid ? req1_data : req0_data;
                        id_q    <= gid;
                        last_q  <= gid;
                        state_q <= EXEC;
                    end
                end
                EXEC: begin
                    cnt_q      <= res_d;
                    rsp_data_q <= res_d;
                    rsp_sat_q  <= sat_d;
                    rsp_id_q   <= id_q;
                    state_q    <= RESP;
                end
                RESP: begin
                    if (rsp_ready) state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp_valid = (state_q == RESP);
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sat   = rsp_sat_q;
    assign q         = cnt_q;

endmodule

// File: tb/tb_sat_counter_arbiter.sv
// Bench for sat_counter_arbiter: directed scenarios plus random commands
// checked against an integer clamp model and a round-robin winner model.
module tb_sat_counter_arbiter;

    localparam int W    = 8;
    localparam int MAXI = 2 ** (W - 1) - 1;
    localparam int MINI = -(2 ** (W - 1));

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req1_valid;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_data, req1_data;
    logic         req0_ready, req1_ready;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_sat;
    logic [W-1:0] rsp_data, q;

    int passed = 0;
    int total  = 0;
    int mq     = 0;
    int mlast  = 1;

    sat_counter_arbiter #(.W(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_op(req0_op),
        .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_op(req1_op),
        .req1_data(req1_data), .req1_ready(req1_ready),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_id(rsp_id), .rsp_data(rsp_data),
        .rsp_sat(rsp_sat), .q(q)
    );

    always #5 clk = ~clk;

    task automatic model_cmd(input logic [1:0] op, input logic [W-1:0] d,
                             output int ed, output bit es);
        int dv, r;
        dv = $signed(d);
        case (op)
            2'd0:    r = mq + dv;
            2'd1:    r = mq - dv;
            2'd2:    r = dv;
            default: r = mq;
        endcase
        es = 0;
        if (r > MAXI) begin r = MAXI; es = 1; end
        if (r < MINI) begin r = MINI; es = 1; end
        mq = r;
        ed = r;
    endtask

    task automatic drive(input bit v0, input logic [1:0] o0, input logic [W-1:0] d0,
                         input bit v1, input logic [1:0] o1, input logic [W-1:0] d1,
                         output int gid, output bit ok);
        @(negedge clk);
        req0_valid = v0; req0_op = o0; req0_data = d0;
        req1_valid = v1; req1_op = o1; req1_data = d1;
        #1;
        ok  = 0;
        gid = -1;
        for (int i = 0; i < 20; i++) begin
            if (req0_ready || req1_ready) begin
                gid = req0_ready ? 0 : 1;
                @(posedge clk);
                #1;
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        req0_valid = 0;
        req1_valid = 0;
    endtask

    task automatic get_rsp(input int stall, output int rid, output int rdata,
                           output bit rsat, output bit ok);
        ok = 0;
        rid = -1; rdata = 0; rsat = 0;
        if (stall > 0) rsp_ready = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        if (ok) begin
            rid   = rsp_id;
            rdata = $signed(rsp_data);
            rsat  = rsp_sat;
            repeat (stall) @(negedge clk);
            rsp_ready = 1;
            @(posedge clk);
            #1;
        end
        rsp_ready = 1;
    endtask

    task automatic test_reset;
        rst = 0;
        req0_valid = 0; req1_valid = 0;
        req0_op = 0; req1_op = 0; req0_data = 0; req1_data = 0;
        rsp_ready = 1;
        #12;
        total++; if (q !== '0) $display("FAIL reset_q got %0d want 0", q); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); else passed++;
        total++; if (rsp_id !== 1'b0) $display("FAIL reset_rsp_id got %b want 0", rsp_id); else passed++;
        total++; if (rsp_data !== '0) $display("FAIL reset_rsp_data got %0d want 0", rsp_data); else passed++;
        total++; if (rsp_sat !== 1'b0) $display("FAIL reset_rsp_sat got %b want 0", rsp_sat); else passed++;
        @(negedge clk);
        rst = 1;
        mq = 0;
        mlast = 1;
    endtask

    task automatic test_load;
        int gid, rid, rd, ed; bit ok, rs, es;
        drive(1, 2'd2, 8'd5, 0, 2'd0, 8'd0, gid, ok);
        total++; if (!ok || gid !== 0) $display("FAIL load_grant got %0d want 0", gid); else passed++;
        total++; if (q !== '0) $display("FAIL load_q_exec got %0d want 0", q); else passed++;
        model_cmd(2'd2, 8'd5, ed, es);
        mlast = 0;
        @(posedge clk); #1;
        total++; if ($signed(q) !== ed) $display("FAIL load_q got %0d want %0d", $signed(q), ed); else passed++;
        total++; if (rsp_valid !== 1'b1) $display("FAIL load_rsp_valid got %b want 1", rsp_valid); else passed++;
        get_rsp(0, rid, rd, rs, ok);
        total++; if (!ok || rid !== 0) $display("FAIL load_rsp_id got %0d want 0", rid); else passed++;
        total++; if (rd !== 5) $display("FAIL load_rsp_data got %0d want 5", rd); else passed++;
        total++; if (rs !== 0) $display("FAIL load_rsp_sat got %0d want 0", rs); else passed++;
    endtask

    task automatic test_saturation;
        logic [1:0]   ops [8] = '{2'd2, 2'd0, 2'd1, 2'd2, 2'd1, 2'd2, 2'd1, 2'd3};
        logic [W-1:0] dats[8] = '{8'd100, 8'd50, 8'd27, 8'h9c, 8'd50, 8'd0, 8'h80, 8'd0};
        int           wd  [8] = '{100, 127, 100, -100, -128, 0, 127, 127};
        bit           ws  [8] = '{0, 1, 0, 0, 1, 0, 1, 0};
        int gid, rid, rd, ed; bit ok, rs, es;
        for (int k = 0; k < 8; k++) begin
            drive(1, ops[k], dats[k], 0, 2'd0, 8'd0, gid, ok);
            model_cmd(ops[k], dats[k], ed, es);
            mlast = 0;
            get_rsp(k % 3, rid, rd, rs, ok);
            total++; if (!ok || rd !== ed || rd !== wd[k])
                $display("FAIL sat_data[%0d] got %0d want %0d", k, rd, wd[k]); else passed++;
            total++; if (rs !== es || rs !== ws[k])
                $display("FAIL sat_flag[%0d] got %0d want %0d", k, rs, ws[k]); else passed++;
            total++; if ($signed(q) !== ed)
                $display("FAIL sat_q[%0d] got %0d want %0d", k, $signed(q), ed); else passed++;
        end
    endtask

    task automatic test_round_robin;
        int gid, rid, rd, ed, cyc; bit ok, rs, es;
        int gq[$], gc[$], rq[$], rdq[$];
        drive(0, 2'd0, 8'd0, 1, 2'd2, 8'd0, gid, ok);
        model_cmd(2'd2, 8'd0, ed, es);
        mlast = 1;
        get_rsp(0, rid, rd, rs, ok);
        @(negedge clk);
        req0_valid = 1; req0_op = 2'd0; req0_data = 8'd1;
        req1_valid = 1; req1_op = 2'd0; req1_data = 8'd1;
        #1;
        cyc = 0;
        while (rq.size() < 4 && cyc < 60) begin
            if (gq.size() >= 4) begin req0_valid = 0; req1_valid = 0; #1; end
            if (req0_ready && req0_valid) begin gq.push_back(0); gc.push_back(cyc); end
            else if (req1_ready && req1_valid) begin gq.push_back(1); gc.push_back(cyc); end
            if (rsp_valid && rsp_ready) begin rq.push_back(rsp_id); rdq.push_back($signed(rsp_data)); end
            @(negedge clk);
            cyc++;
        end
        req0_valid = 0; req1_valid = 0;
        total++; if (rq.size() != 4 || gq.size() != 4)
            $display("FAIL rr_count got %0d/%0d want 4/4", gq.size(), rq.size()); else passed++;
        for (int k = 0; k < 4 && k < gq.size() && k < rq.size(); k++) begin
            int w;
            w = 1 - mlast;
            mlast = w;
            model_cmd(2'd0, 8'd1, ed, es);
            total++; if (gq[k] !== w) $display("FAIL rr_grant[%0d] got %0d want %0d", k, gq[k], w); else passed++;
            total++; if (rq[k] !== w) $display("FAIL rr_rsp_id[%0d] got %0d want %0d", k, rq[k], w); else passed++;
            total++; if (rdq[k] !== ed) $display("FAIL rr_rsp_data[%0d] got %0d want %0d", k, rdq[k], ed); else passed++;
            if (k > 0) begin
                total++; if (gc[k] - gc[k-1] !== 3)
                    $display("FAIL rr_interval[%0d] got %0d want 3", k, gc[k] - gc[k-1]); else passed++;
            end
        end
    endtask

    task automatic test_backpressure;
        int w, ed, cd, rid, rd; bit es, ok, rs;
        logic cid;
        @(negedge clk);
        rsp_ready = 0;
        req0_valid = 1; req0_op = 2'd0; req0_data = 8'd1;
        req1_valid = 1; req1_op = 2'd0; req1_data = 8'd1;
        w = 1 - mlast; mlast = w;
        model_cmd(2'd0, 8'd1, ed, es);
        ok = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (rsp_valid) begin ok = 1; break; end
        end
        cd = $signed(rsp_data); cid = rsp_id;
        total++; if (!ok || cid !== w[0]) $display("FAIL bp_id got %0d want %0d", cid, w); else passed++;
        total++; if (cd !== ed) $display("FAIL bp_data got %0d want %0d", cd, ed); else passed++;
        for (int k = 0; k < 4; k++) begin
            total++; if (rsp_valid !== 1'b1) $display("FAIL bp_valid[%0d] got %b want 1", k, rsp_valid); else passed++;
            total++; if ($signed(rsp_data) !== cd) $display("FAIL bp_hold_data[%0d] got %0d want %0d", k, $signed(rsp_data), cd); else passed++;
            total++; if (rsp_id !== cid) $display("FAIL bp_hold_id[%0d] got %b want %b", k, rsp_id, cid); else passed++;
            total++; if ((req0_ready | req1_ready) !== 1'b0)
                $display("FAIL bp_ready[%0d] got %b%b want 00", k, req1_ready, req0_ready); else passed++;
            total++; if ($signed(q) !== ed) $display("FAIL bp_q[%0d] got %0d want %0d", k, $signed(q), ed); else passed++;
            @(negedge clk);
        end
        rsp_ready = 1;
        @(negedge clk);
        w = 1 - mlast; mlast = w;
        total++; if ((w == 0 ? req0_ready : req1_ready) !== 1'b1 || (w == 0 ? req1_ready : req0_ready) !== 1'b0)
            $display("FAIL bp_next_grant got %b%b want winner %0d", req1_ready, req0_ready, w); else passed++;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        model_cmd(2'd0, 8'd1, ed, es);
        get_rsp(0, rid, rd, rs, ok);
        total++; if (!ok || rid !== w || rd !== ed)
            $display("FAIL bp_after got id %0d data %0d want id %0d data %0d", rid, rd, w, ed); else passed++;
    endtask

    task automatic test_reset_mid;
        int gid, rid, rd; bit ok, rs, sawv;
        drive(1, 2'd2, 8'd42, 0, 2'd0, 8'd0, gid, ok);
        rst = 0;
        #1;
        mq = 0; mlast = 1;
        total++; if (q !== '0) $display("FAIL rstmid_q got %0d want 0", q); else passed++;
        total++; if (rsp_valid !== 1'b0) $display("FAIL rstmid_valid got %b want 0", rsp_valid); else passed++;
        @(negedge clk);
        rst = 1;
        sawv = 0;
        repeat (3) begin @(negedge clk); if (rsp_valid) sawv = 1; end
        total++; if (sawv !== 0) $display("FAIL rstmid_no_rsp got 1 want 0"); else passed++;
        req0_valid = 1; req0_op = 2'd3; req0_data = 8'd0;
        req1_valid = 1; req1_op = 2'd3; req1_data = 8'd0;
        #1;
        total++; if (req0_ready !== 1'b1 || req1_ready !== 1'b0)
            $display("FAIL rstmid_first got %b%b want 01", req1_ready, req0_ready); else passed++;
        @(posedge clk); #1;
        req0_valid = 0; req1_valid = 0;
        mlast = 0;
        get_rsp(1, rid, rd, rs, ok);
        total++; if (!ok || rid !== 0 || rd !== 0 || rs !== 0)
            $display("FAIL rstmid_read got id %0d data %0d sat %0d want 0 0 0", rid, rd, rs); else passed++;
    endtask

    task automatic test_random;
        int gid, rid, rd, ed, w, v; bit ok, rs, es;
        logic [1:0] o0, o1;
        logic [W-1:0] d0, d1;
        for (int k = 0; k < 40; k++) begin
            v  = $urandom_range(1, 3);
            o0 = 2'($urandom_range(0, 3)); o1 = 2'($urandom_range(0, 3));
            d0 = W'($urandom); d1 = W'($urandom);
            if (v == 3) w = 1 - mlast;
            else w = (v == 1) ? 0 : 1;
            drive(v[0], o0, d0, v[1], o1, d1, gid, ok);
            total++; if (!ok || gid !== w) $display("FAIL rnd_grant[%0d] got %0d want %0d", k, gid, w); else passed++;
            mlast = w;
            model_cmd(w == 0 ? o0 : o1, w == 0 ? d0 : d1, ed, es);
            get_rsp($urandom_range(0, 3), rid, rd, rs, ok);
            total++; if (!ok || rid !== w || rd !== ed || rs !== es)
                $display("FAIL rnd_rsp[%0d] got id %0d data %0d sat %0d want %0d %0d %0d",
                         k, rid, rd, rs, w, ed, es); else passed++;
            total++; if ($signed(q) !== ed) $display("FAIL rnd_q[%0d] got %0d want %0d", k, $signed(q), ed); else passed++;
        end
    endtask

    initial begin
        test_reset;
        test_load;
        test_saturation;
        test_round_robin;
        test_backpressure;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/sat_counter_arbiter.md
Name: sat_counter_arbiter

Overview:
Shares one saturating signed W-bit accumulator between two requesters. Each requester issues ADD, SUB, LOAD or READ commands over a valid/ready handshake. A round-robin arbiter grants one command at a time, and a 3-state FSM executes it and returns the result on a single response channel with backpressure. The block sits between client logic and the accumulator datapath and is the only writer of the count register.

Parameters:
W, 8, datapath width. Count, operands and responses are two's-complement signed, W >= 2.

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous, active-low reset (0 = reset)
req0_valid  input  1  requester 0 command valid
req0_op  input  2  requester 0 opcode: 00 ADD, 01 SUB, 10 LOAD, 11 READ
req0_data  input  W  requester 0 signed operand (ignored for READ)
req0_ready  output  1  requester 0 command accepted this cycle
req1_valid  input  1  requester 1 command valid
req1_op  input  2  requester 1 opcode (same encoding)
req1_data  input  W  requester 1 signed operand
req1_ready  output  1  requester 1 command accepted this cycle
rsp_valid  output  1  response valid
rsp_ready  input  1  response consumer ready
rsp_id  output  1  index of the requester that issued the command
rsp_data  output  W  signed count value after the command
rsp_sat  output  1  1 when the command's result was clamped
q  output  W  current count register (signed)

Behaviour:
- Reset (rst=0, asynchronous):
  - q=0, state=IDLE, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_sat=0.
  - last_grant=1, so requester 0 wins first.
  - Takes effect immediately, mid-command included; any in-flight command or pending response is discarded.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Only one reqN_ready may be 1, only in IDLE. Ready is combinational from state, the valids and last_grant. It never depends on rsp_ready.
  - One valid: grant it.
  - Both valid: grant the requester != last_grant.
  - On grant (valid & ready), register op, data and id; set last_grant=id; go to EXEC.
  - No valid: stay in IDLE.
- EXEC (exactly 1 cycle):
  - Update q and register rsp_data, rsp_sat and rsp_id; go to RESP.
- RESP:
  - rsp_valid=1; rsp_id, rsp_data and rsp_sat held stable.
  - On rsp_valid & rsp_ready, go to IDLE, with rsp_valid=0 next cycle.
- Latency: a command accepted at edge t updates q at edge t+1; rsp_valid is high from t+1. The minimum issue interval is 3 cycles.
- Arithmetic:
  - ADD: compute q+data in W+1 bits. SUB: compute q-data in W+1 bits.
  - Result > 2^(W-1)-1: clamp to 2^(W-1)-1, rsp_sat=1.
  - Result < -2^(W-1): clamp to -2^(W-1), rsp_sat=1.
  - Otherwise the result is exact, rsp_sat=0.
  - SUB of data=-2^(W-1) is handled by the W+1-bit rule (e.g. 0-(-128) clamps to 127, sat=1).
- LOAD: q=data, rsp_sat=0.
- READ: q unchanged, rsp_data=q, rsp_sat=0.
- Requester rule: valid, op and data are held until ready. The block samples them only on grant.
- A requester whose valid stays high while not granted is not starved. Round-robin guarantees a grant within 2 commands.
- q changes only in EXEC.

Test Plan:
- Reset then req0 LOAD 5 -> req0_ready=1 in IDLE; q=5 one cycle later; rsp_valid=1, rsp_id=0, rsp_data=5, rsp_sat=0.
- LOAD 100, then ADD 50 -> rsp_data=127, rsp_sat=1, q=127. Then SUB 27 -> rsp_data=100, sat=0.
- LOAD -100, SUB 50 -> rsp_data=-128, sat=1. Then LOAD 0, SUB -128 -> rsp_data=127, sat=1.
- Both requesters hold valid with ADD 1 and rsp_ready=1 -> grants 0,1,0,1; rsp_id 0,1,0,1; rsp_data 1,2,3,4; a new grant every 3 cycles.
- rsp_ready=0 for 4 cycles during RESP with both valids high -> rsp_valid, rsp_data and rsp_id stable; both readys 0; q unchanged. After rsp_ready=1, the next grant occurs one cycle later.
- rst pulsed low during EXEC after LOAD 42 -> q=0 and rsp_valid=0 immediately, no response emitted. After release, with both valid, req0 is granted first.
